npu_out_serializer: RTL and testbench
=====================================

// Module: npu_out_serializer
// PURPOSE
//  Downstream stage of the NPU convolution core. Captures each 18-channel x 8-bit clipped result vector
//  and applies optional ReLU. Buffers vectors in a small FIFO and serialises each one into
//  BEATS narrow beats on a valid/ready stream toward the output feature-map buffer. The core has no
//  ready input, so this block raises almost_full for the controller and flags overflow on data loss.
// PARAMETERS
//  NPU_OUT_NUM   18  output channels per result vector
//  DATA_WIDTH    8   bits per channel (signed, two's complement)
//  BEATS         2   beats per vector; NPU_OUT_NUM % BEATS == 0; beat width BW = NPU_OUT_NUM*DATA_WIDTH/BEATS (72)
//  FIFO_DEPTH    4   vector entries; power of two, >= 2
// PORTS
//  clk         in   1                      clock, all logic on rising edge
//  rstn        in   1                      synchronous active-low reset
//  relu_en     in   1                      1: clamp negative lanes to 0 on write
//  in_data     in   NPU_OUT_NUM*DATA_WIDTH  result vector; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//  in_valid    in   1                      in_data valid this cycle (no ready; push-only)
//  almost_full out  1                      level >= FIFO_DEPTH-1
//  level       out  $clog2(FIFO_DEPTH)+1    number of stored vectors
//  overflow    out  1                      sticky: a vector was dropped
//  ovf_clr     in   1                      clears overflow
//  out_data    out  BW                     current beat
//  out_valid   out  1                      out_data valid
//  out_ready   in   1                      consumer accepts beat
//  out_last    out  1                      current beat is beat BEATS-1 of its vector
// BEHAVIOUR
//  - Reset (rstn==0 at clk edge): wr/rd pointers, level, beat counter, overflow all cleared; out_valid=0,
//    out_last=0, out_data=0, almost_full=0. Stored contents discarded; reset mid-vector drops partial beats.
//  - Write: in_valid && (level<FIFO_DEPTH || pop) -> entry stored at wr_ptr, wr_ptr++ (wraps mod FIFO_DEPTH).
//    Lane transform at write: relu_en && lane[DATA_WIDTH-1] -> lane=0, else unchanged. relu_en sampled per write.
//  - Drop: in_valid && level==FIFO_DEPTH && !pop -> vector discarded, overflow<=1 next cycle, FIFO unchanged.
//  - Simultaneous pop and push when full: push accepted, level unchanged.
//  - overflow: set has priority over ovf_clr in the same cycle.
//  - Read: out_valid = (level!=0). out_data = head[beat*BW +: BW]; beat 0 = channels 0..8.
//    out_last = out_valid && beat==BEATS-1.
//  - Beat handshake: out_valid && out_ready -> beat++. On the last beat, beat<=0 and pop (rd_ptr++, level--).
//  - While out_valid && !out_ready: out_data/out_last held stable, and out_valid is not withdrawn.
//  - Latency: vector written at edge N -> out_valid=1 at N+1 when the FIFO was empty (registered storage,
//    combinational head select). Full throughput: one beat per cycle under continuous out_ready.
//  - level = push - pop, registered. almost_full is a combinational function of level.
//  - Empty FIFO: out_ready ignored; beat stays 0.
// TESTING
//  1 Reset then push one vector (ch c = c+1), relu_en=0, out_ready=1 -> out_valid at next cycle;
//    beat0 = ch0..8 = 1..9, out_last=0; beat1 = ch9..17 = 10..18, out_last=1; level returns 0.
//  2 relu_en=1, push ch0=8'h80, ch1=8'hFF, ch2=8'h7F, ch3=8'h00 -> beat0 lanes 0..3 = 00,00,7F,00.
//    Repeat with relu_en=0 -> 80,FF,7F,00.
//  3 out_ready=0, push 4 vectors -> level=4, almost_full=1 after the 3rd push; 5th push -> overflow=1,
//    level=4; drain yields vectors 1-4 in order, with no trace of vector 5.
//  4 Full FIFO, out_ready=1 on the last beat of the head in the same cycle as in_valid -> push accepted,
//    level stays 4, overflow stays 0.
//  5 Random out_ready toggling during 20 pushes spaced >= 2 cycles -> out_data stable while stalled,
//    40 beats received in order, every 2nd beat has out_last.
//  6 rstn=0 for one cycle after beat0 of a vector -> next cycle out_valid=0, level=0, overflow=0;
//    a new push then starts at beat0.

Source files
------------

// File: rtl/npu_out_serializer.sv
// Output serializer for the NPU convolution core: optional ReLU on capture, a small vector FIFO,
// and a BEATS-per-vector valid/ready stream with almost_full and sticky overflow for the controller.
module npu_out_serializer #(
  parameter  int NPU_OUT_NUM = 18,
  parameter  int DATA_WIDTH  = 8,
  parameter  int BEATS       = 2,
  parameter  int FIFO_DEPTH  = 4,
  localparam int VEC_W       = NPU_OUT_NUM * DATA_WIDTH,
  localparam int BW          = VEC_W / BEATS,
  localparam int PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1,
  localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             relu_en,
  input  logic [VEC_W-1:0] in_data,
  input  logic             in_valid,
  output logic             almost_full,
  output logic [LVL_W-1:0] level,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [BW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  LVL_AF    = LVL_W'(FIFO_DEPTH - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

  // Lanes are two's complement; the sign bit alone decides the clamp.
  function automatic logic [VEC_W-1:0] relu_vec(input logic [VEC_W-1:0] vec, input logic en);
    logic [VEC_W-1:0]             res;
    logic signed [DATA_WIDTH-1:0] lane;
    res = vec;
    for (int c = 0; c < NPU_OUT_NUM; c++) begin
      lane = vec[c*DATA_WIDTH +: DATA_WIDTH];
      if (en && (lane < 0)) begin
        res[c*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
    return res;
  endfunction

  logic [VEC_W-1:0]  mem_p0 [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [BEAT_W-1:0] beat_q;
  logic              ovf_q;

  logic              vld_p0;
  logic              hs;
  logic              pop;
  logic              push;
  logic              drop;
  logic [VEC_W-1:0]  head;
  logic [BW-1:0]     head_beat [BEATS];

  assign vld_p0 = (level_q != '0);
  assign hs     = vld_p0 && out_ready;
  assign pop    = hs && (beat_q == BEAT_LAST);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push   = in_valid && ((level_q != LVL_FULL) || pop);
  assign drop   = in_valid && !push;

  // Stage p0: control state (pointers, occupancy, beat index, overflow flag)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (!push && pop) begin
        level_q <= level_q - 1'b1;
      end
      if (hs) beat_q <= pop ? '0 : beat_q + 1'b1;
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Stage p0: vector storage, written post-ReLU; contents are not reset
  always_ff @(posedge clk) begin
    if (push) mem_p0[wr_ptr] <= relu_vec(in_data, relu_en);
  end

  // Head select and beat slicing are combinational off the registered storage
  assign head = mem_p0[rd_ptr];

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    assign head_beat[b] = head[b*BW +: BW];
  end

  assign out_valid   = vld_p0;
  assign out_data    = vld_p0 ? head_beat[beat_q] : '0;
  assign out_last    = vld_p0 && (beat_q == BEAT_LAST);
  assign level       = level_q;
  assign almost_full = (level_q >= LVL_AF);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_npu_out_serializer.sv
// Scoreboard bench for npu_out_serializer: a queue-based reference model predicts beats, a monitor
// compares every handshake plus level/flags each cycle, and directed plus random scenarios drive it.
module tb_npu_out_serializer;
  localparam int N     = 18;
  localparam int DW    = 8;
  localparam int BEATS = 2;
  localparam int DEPTH = 4;
  localparam int VW    = N * DW;
  localparam int BW    = VW / BEATS;
  localparam int LPB   = N / BEATS;

  typedef struct packed {
    logic [BW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          relu_en;
  logic [VW-1:0] in_data;
  logic          in_valid;
  logic          almost_full;
  logic [2:0]    level;
  logic          overflow;
  logic          ovf_clr;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  npu_out_serializer dut (
    .clk(clk), .rstn(rstn), .relu_en(relu_en), .in_data(in_data), .in_valid(in_valid),
    .almost_full(almost_full), .level(level), .overflow(overflow), .ovf_clr(ovf_clr),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  beat_t         sb[$];
  logic [VW-1:0] mq[$];
  int            mbeat    = 0;
  logic          movf     = 1'b0;

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] xform(input logic [VW-1:0] v, input logic relu);
    logic [VW-1:0] r;
    logic [DW-1:0] b;
    for (int c = 0; c < N; c++) begin
      b = v[c*DW +: DW];
      if (relu && b[DW-1]) b = '0;
      r[c*DW +: DW] = b;
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] beat_of(input logic [VW-1:0] v, input int bi);
    logic [BW-1:0] r;
    for (int k = 0; k < LPB; k++) r[k*DW +: DW] = v[(bi*LPB + k)*DW +: DW];
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = 8'($urandom);
    return v;
  endfunction

  function automatic logic [VW-1:0] fill_vec(input int base);
    logic [VW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = 8'(base + c);
    return v;
  endfunction

  // Reference model: FIFO of transformed vectors, beat index and sticky overflow.
  initial begin
    logic          hs, pop, acc;
    logic [VW-1:0] v;
    forever begin
      @(posedge clk);
      if (rstn !== 1'b1) begin
        mq.delete();
        sb.delete();
        mbeat = 0;
        movf  = 1'b0;
      end else begin
        hs  = (mq.size() != 0) && out_ready;
        pop = hs && (mbeat == BEATS - 1);
        acc = in_valid && ((mq.size() < DEPTH) || pop);
        if (hs) mbeat = pop ? 0 : mbeat + 1;
        if (pop) void'(mq.pop_front());
        if (acc) begin
          v = xform(in_data, relu_en);
          mq.push_back(v);
          for (int b = 0; b < BEATS; b++) sb.push_back('{d: beat_of(v, b), l: (b == BEATS - 1)});
        end
        if (in_valid && !acc) movf = 1'b1;
        else if (ovf_clr)     movf = 1'b0;
      end
    end
  end

  // Monitor: flags and level every cycle, beats on handshake, stability while stalled.
  initial begin
    logic          stall;
    logic [BW-1:0] pd;
    logic          pl;
    beat_t         e;
    stall = 1'b0;
    pd    = '0;
    pl    = 1'b0;
    forever begin
      @(negedge clk);
      if (rstn !== 1'b1) begin
        stall = 1'b0;
      end else begin
        check("level", BW'(level), BW'(mq.size()));
        check("almost_full", BW'(almost_full), BW'(mq.size() >= DEPTH - 1));
        check("overflow", BW'(overflow), BW'(movf));
        check("out_valid", BW'(out_valid), BW'(mq.size() != 0));
        if (stall) begin
          check("stall_valid", BW'(out_valid), BW'(1'b1));
          check("stall_data", out_data, pd);
          check("stall_last", BW'(out_last), BW'(pl));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_beat", out_data, '0);
          end else begin
            e = sb.pop_front();
            check("beat_data", out_data, e.d);
            check("beat_last", BW'(out_last), BW'(e.l));
          end
        end
        stall = out_valid && !out_ready;
        pd    = out_data;
        pl    = out_last;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && mq.size() == 0) break;
      step();
    end
    check("drain_done", BW'(sb.size()), '0);
    check("drain_level", BW'(level), '0);
  endtask

  initial begin
    logic [VW-1:0] v;
    rstn = 1'b0; relu_en = 1'b0; in_data = '0; in_valid = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0;
    step(); step();
    rstn = 1'b1;
    step();
    check("rst_out_valid", BW'(out_valid), '0);
    check("rst_out_last", BW'(out_last), '0);
    check("rst_out_data", out_data, '0);
    check("rst_level", BW'(level), '0);
    check("rst_overflow", BW'(overflow), '0);
    check("rst_almost_full", BW'(almost_full), '0);

    // Single vector, channel c = c+1
    out_ready = 1'b1;
    v = fill_vec(1);
    in_data = v; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_valid", BW'(out_valid), BW'(1'b1));
    check("t1_beat0", out_data, 72'h09_08_07_06_05_04_03_02_01);
    check("t1_last0", BW'(out_last), '0);
    step();
    check("t1_beat1", out_data, 72'h12_11_10_0F_0E_0D_0C_0B_0A);
    check("t1_last1", BW'(out_last), BW'(1'b1));
    step();
    check("t1_level0", BW'(level), '0);

    // ReLU on and off
    v = fill_vec(16);
    v[31:0] = 32'h00_7F_FF_80;
    in_data = v; relu_en = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t2_relu_on", BW'(out_data[31:0]), BW'(32'h00_7F_00_00));
    step(); step();
    relu_en = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t2_relu_off", BW'(out_data[31:0]), BW'(32'h00_7F_FF_80));
    step(); step();

    // Fill, overflow, overflow set-vs-clear priority, drain
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_data = fill_vec(k * 32); in_valid = 1'b1;
      step();
      if (k == 3) check("t3_af_at3", BW'(almost_full), BW'(1'b1));
      if (k == 4) check("t3_level4", BW'(level), BW'(4));
    end
    in_valid = 1'b0;
    check("t3_ovf", BW'(overflow), BW'(1'b1));
    check("t3_level_after_drop", BW'(level), BW'(4));
    in_data = fill_vec(200); in_valid = 1'b1; ovf_clr = 1'b1;
    step();
    in_valid = 1'b0;
    check("t3_ovf_set_wins", BW'(overflow), BW'(1'b1));
    step();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", BW'(overflow), '0);
    drain();

    // Push accepted on the cycle the full FIFO pops
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_data = rand_vec(); in_valid = 1'b1;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    in_data = rand_vec(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t4_level", BW'(level), BW'(4));
    check("t4_no_ovf", BW'(overflow), '0);
    drain();

    // Random backpressure with spaced random pushes
    for (int k = 0; k < 20; k++) begin
      in_data = rand_vec(); relu_en = 1'($urandom); in_valid = 1'b1;
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      in_valid = 1'b0;
      for (int j = 0; j < $urandom_range(1, 3); j++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        step();
      end
    end
    drain();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;

    // Reset after the first beat of a vector
    out_ready = 1'b1;
    in_data = rand_vec(); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("t6_valid", BW'(out_valid), '0);
    check("t6_level", BW'(level), '0);
    check("t6_ovf", BW'(overflow), '0);
    v = rand_vec();
    in_data = v; relu_en = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t6_restart_beat0", out_data, beat_of(v, 0));
    check("t6_restart_last", BW'(out_last), '0);
    drain();

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
